calc_op_sequencer: RTL and testbench

Control FSM for the 4-bit calculator datapath: adder, subtractor, multiplier, multi-cycle divider and 4-way result mux. Detects operation-button presses, latches operands from the switches and drives the mux select. Issues a one-cycle start to the divider and waits for its done, with an optional timeout. Captures the selected result, or the error code, into a held LED register. Sits between board I/O (sw, bt, ld) and the datapath instances in the calculator top.

---
 rtl/calc_pkg.sv | 17 +
 rtl/calc_op_sequencer_bt_edge_det.sv | 28 ++
 rtl/calc_op_sequencer.sv | 152 +++++++++++++++
 tb/tb_calc_op_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the 4-bit calculator control path.
// The divider-timeout option is selected with CALC_OP_SEQUENCER_TIMEOUT_EN.
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_MUL   = 4'b0100;
    localparam logic [3:0] OP_DIV   = 4'b1000;
    localparam logic [7:0] ERR_CODE = 8'hFF;

endpackage

// File: rtl/calc_op_sequencer_bt_edge_det.sv
// Registered rising-edge detector on the four operation buttons, followed by
// a lowest-index-wins one-hot priority encoder.
module bt_edge_det (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bt,
    output logic [3:0] grant,
    output logic       any_press
);

    logic [3:0] bt_q_reg;
    logic [3:0] press;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bt_q_reg <= 4'b0000;
        end else begin
            bt_q_reg <= bt;
        end
    end

    assign press = bt & ~bt_q_reg;

    // Isolate the lowest set bit: x & -x.
    assign grant     = press & (~press + 4'd1);
    assign any_press = |press;

endmodule

// File: rtl/calc_op_sequencer.sv
// Control FSM for the calculator datapath: latches operands on a button press,
// steers the result mux, sequences the divider and holds the result on ld.
// Optional divider timeout: define CALC_OP_SEQUENCER_TIMEOUT_EN.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter int BITS        = 8,
    parameter int DIV_TIMEOUT = 255,
    parameter int TW          = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BITS-1:0]   sw,
    input  logic [3:0]        bt,
    output logic [BITS/2-1:0] op_a,
    output logic [BITS/2-1:0] op_b,
    output logic [3:0]        op_sel,
    output logic              div_start,
    input  logic              div_done,
    input  logic [BITS-1:0]   res_in,
    input  logic              sub_err,
    input  logic              div_err,
    output logic [BITS-1:0]   ld,
    output logic              busy,
    output logic              done,
    output logic              timeout
);

    localparam int HB = BITS / 2;

    state_t            state_reg, state_next;
    logic [HB-1:0]     op_a_reg, op_a_next;
    logic [HB-1:0]     op_b_reg, op_b_next;
    logic [3:0]        op_sel_reg, op_sel_next;
    logic [BITS-1:0]   ld_reg, ld_next;
    logic              done_reg, done_next;
    logic [3:0]        grant;
    logic              any_press;
`ifdef CALC_OP_SEQUENCER_TIMEOUT_EN
    logic [TW-1:0]     cnt_reg, cnt_next;
    logic              timeout_reg, timeout_next;
`endif

    bt_edge_det u_bt_edge_det (
        .clk       (clk),
        .rst       (rst),
        .bt        (bt),
        .grant     (grant),
        .any_press (any_press)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= IDLE;
            op_a_reg    <= '0;
            op_b_reg    <= '0;
            op_sel_reg  <= OP_ADD;
            ld_reg      <= '0;
            done_reg    <= 1'b0;
`ifdef CALC_OP_SEQUENCER_TIMEOUT_EN
            cnt_reg     <= '0;
            timeout_reg <= 1'b0;
`endif
        end else begin
            state_reg   <= state_next;
            op_a_reg    <= op_a_next;
            op_b_reg    <= op_b_next;
            op_sel_reg  <= op_sel_next;
            ld_reg      <= ld_next;
            done_reg    <= done_next;
`ifdef CALC_OP_SEQUENCER_TIMEOUT_EN
            cnt_reg     <= cnt_next;
            timeout_reg <= timeout_next;
`endif
        end
    end

    always_comb begin
        state_next   = state_reg;
        op_a_next    = op_a_reg;
        op_b_next    = op_b_reg;
        op_sel_next  = op_sel_reg;
        ld_next      = ld_reg;
        done_next    = 1'b0;
        div_start    = 1'b0;
`ifdef CALC_OP_SEQUENCER_TIMEOUT_EN
        cnt_next     = cnt_reg;
        timeout_next = timeout_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (any_press) begin
                    op_a_next   = sw[BITS-1:HB];
                    op_b_next   = sw[HB-1:0];
                    op_sel_next = grant;
`ifdef CALC_OP_SEQUENCER_TIMEOUT_EN
                    timeout_next = 1'b0;
`endif
                    state_next  = EXEC;
                end
            end
            EXEC: begin
                if (op_sel_reg == OP_DIV) begin
                    div_start  = 1'b1;
`ifdef CALC_OP_SEQUENCER_TIMEOUT_EN
                    cnt_next   = '0;
`endif
                    state_next = DIV_WAIT;
                end else begin
                    // Add/sub/mul settle combinationally on the latched operands.
                    ld_next    = (op_sel_reg[1] && sub_err) ? BITS'(ERR_CODE) : res_in;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
            end
            DIV_WAIT: begin
                if (div_done) begin
                    ld_next    = div_err ? BITS'(ERR_CODE) : res_in;
                    done_next  = 1'b1;
                    state_next = IDLE;
                end
`ifdef CALC_OP_SEQUENCER_TIMEOUT_EN
                // cnt_reg counts completed wait cycles, so this is wait cycle DIV_TIMEOUT.
                else if (cnt_reg == TW'(DIV_TIMEOUT - 1)) begin
                    ld_next      = BITS'(ERR_CODE);
                    timeout_next = 1'b1;
                    done_next    = 1'b1;
                    state_next   = IDLE;
                end else begin
                    cnt_next = cnt_reg + TW'(1);
                end
`endif
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign op_a   = op_a_reg;
    assign op_b   = op_b_reg;
    assign op_sel = op_sel_reg;
    assign ld     = ld_reg;
    assign done   = done_reg;
    assign busy   = (state_reg == EXEC) || (state_reg == DIV_WAIT);
`ifdef CALC_OP_SEQUENCER_TIMEOUT_EN
    assign timeout = timeout_reg;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Scoreboard bench for calc_op_sequencer: behavioural datapath and divider
// models, directed scenarios, then randomized operations with busy-time noise.
module tb_calc_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] sw  = 8'h00;
    logic [3:0] bt  = 4'h0;
    logic [3:0] op_a, op_b, op_sel;
    logic       div_start;
    logic       div_done = 1'b0;
    logic [7:0] res_in;
    logic       sub_err, div_err;
    logic [7:0] ld;
    logic       busy, done, timeout;

    calc_op_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .bt        (bt),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .div_start (div_start),
        .div_done  (div_done),
        .res_in    (res_in),
        .sub_err   (sub_err),
        .div_err   (div_err),
        .ld        (ld),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ld;
        logic       to;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Datapath environment: plain arithmetic on whatever operands the DUT presents.
    logic [7:0] div_q = 8'h00;
    always_comb begin
        sub_err = (op_a < op_b);
        div_err = (op_b == 4'd0);
        case (op_sel)
            4'b0001: res_in = 8'(op_a) + 8'(op_b);
            4'b0010: res_in = 8'(op_a) - 8'(op_b);
            4'b0100: res_in = 8'(op_a) * 8'(op_b);
            4'b1000: res_in = div_q;
            default: res_in = 8'h5A;
        endcase
    end

    // Divider: completes div_lat cycles after the start pulse; div_lat < 0 never completes.
    int div_lat    = 1;
    int div_cnt    = -1;
    int div_starts = 0;
    initial forever begin
        @(negedge clk);
        div_done = 1'b0;
        if (!rst) begin
            div_cnt = -1;
        end else if (div_start) begin
            div_starts++;
            div_cnt = div_lat;
        end else if (div_cnt > 0) begin
            div_cnt--;
            if (div_cnt == 0) begin
                div_q    = (op_b == 4'd0) ? 8'h00 : 8'(op_a / op_b);
                div_done = 1'b1;
                div_cnt  = -1;
            end
        end
    end

    // Monitor: every done pulse must match the oldest outstanding expectation.
    exp_t got;
    initial forever begin
        @(negedge clk);
        if (rst && done) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual_ld=%0h required=no_done", ld);
            end else begin
                got = sb.pop_front();
                check("ld", ld, got.ld);
                check("timeout_flag", timeout, got.to);
            end
        end
    end

    function automatic int winner(input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (b[i]) return i;
        return 0;
    endfunction

    function automatic exp_t model(input logic [7:0] s, input logic [3:0] b, input int lat);
        exp_t e;
        int a = s[7:4];
        int d = s[3:0];
        e.to = 1'b0;
        case (winner(b))
            0: e.ld = 8'(a + d);
            1: e.ld = (a < d) ? 8'hFF : 8'(a - d);
            2: e.ld = 8'(a * d);
            default: begin
                if (lat < 0) begin
                    e.ld = 8'hFF;
                    e.to = 1'b1;
                end else begin
                    e.ld = (d == 0) ? 8'hFF : 8'(a / d);
                end
            end
        endcase
        return e;
    endfunction

    task automatic do_op(input logic [7:0] s, input logic [3:0] b, input int lat,
                         input bit noise, output int busy_cycles);
        exp_t e;
        e = model(s, b, lat);
        div_lat = lat;
        @(posedge clk); #1;
        sw = s;
        bt = b;
        sb.push_back(e);
        @(posedge clk); #1;
        bt = 4'h0;
        check("op_sel", op_sel, 4'b0001 << winner(b));
        check("operands", {op_a, op_b}, s);
        busy_cycles = 0;
        while (busy && busy_cycles < 600) begin
            busy_cycles++;
            if (noise) begin
                bt = 4'($urandom);
                sw = 8'($urandom);
            end
            @(posedge clk); #1;
        end
        bt = 4'h0;
        check("busy_released", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("done_seen", sb.size(), 0);
        sb.delete();
        check("ld_held", ld, e.ld);
        check("operands_stable", {op_sel, op_a, op_b}, {4'b0001 << winner(b), s});
        $display("op sw=%02h bt=%b lat=%0d noise=%0d busy=%0d ld=%02h", s, b, lat, noise, busy_cycles, ld);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    int bc;
    int starts0;
    exp_t eh;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ld", ld, 8'h00);
        check("rst_op_sel", op_sel, 4'b0001);
        check("rst_operands", {op_a, op_b}, 8'h00);
        check("rst_flags", {busy, done, timeout, div_start}, 4'b0000);
        rst = 1'b1;

        do_op(8'h53, 4'b0001, 1, 1'b0, bc);
        check("add_busy_cycles", bc, 1);
        do_op(8'h35, 4'b0010, 1, 1'b0, bc);
        do_op(8'h53, 4'b0010, 1, 1'b0, bc);
        do_op(8'hFF, 4'b0110, 1, 1'b0, bc);
        do_op(8'hFF, 4'b0100, 1, 1'b0, bc);

        starts0 = div_starts;
        do_op(8'h93, 4'b1000, 20, 1'b1, bc);
        check("div_busy_cycles", bc, 21);
        check("div_start_pulses", div_starts - starts0, 1);

        // A button held for many cycles fires exactly once.
        eh = model(8'h12, 4'b0001, 1);
        @(posedge clk); #1;
        sw = 8'h12;
        bt = 4'b0001;
        sb.push_back(eh);
        repeat (12) @(posedge clk);
        #1;
        bt = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        check("held_done_seen", sb.size(), 0);
        sb.delete();
        $display("held sw=12 bt=0001 ld=%02h", ld);

`ifdef CALC_OP_SEQUENCER_TIMEOUT_EN
        do_op(8'h93, 4'b1000, -1, 1'b0, bc);
        check("timeout_busy_cycles", bc, 256);
        check("timeout_sticky", timeout, 1'b1);
        do_op(8'h21, 4'b0001, 1, 1'b0, bc);
        check("timeout_cleared", timeout, 1'b0);
`endif

        // Divide that never completes, aborted by an asynchronous reset.
        div_lat = -1;
        @(posedge clk); #1;
        sw = 8'h84;
        bt = 4'b1000;
        @(posedge clk); #1;
        bt = 4'h0;
`ifdef CALC_OP_SEQUENCER_TIMEOUT_EN
        repeat (50) @(posedge clk);
`else
        repeat (300) @(posedge clk);
`endif
        #1;
        check("div_wait_busy", busy, 1'b1);
        check("div_wait_no_timeout", timeout, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        check("abort_ld", ld, 8'h00);
        check("abort_flags", {busy, done, div_start, timeout}, 4'b0000);
        check("abort_op_sel", op_sel, 4'b0001);
        $display("reset mid DIV_WAIT ld=%02h busy=%0d", ld, busy);
        @(posedge clk); #1;
        rst = 1'b1;
        do_op(8'h62, 4'b0001, 1, 1'b0, bc);

        for (int n = 0; n < 40; n++) begin
            do_op(8'($urandom), 4'($urandom_range(1, 15)), $urandom_range(1, 30),
                  1'($urandom), bc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
